// File: rtl/playback_sequencer.sv
// playback_sequencer
//   Fetches one 16-bit little-endian audio sample (two flash bytes) per
//   accepted sample-sync pulse and applies playback commands (song select,
//   restart, speed) only between fetches.
// Ports:
//   CLOCK, Reset          clock and synchronous active-high reset
//   play                  1 = playing, 0 = paused (output silence)
//   sample_req            one-cycle sample-sync pulse
//   restart, next_song, prev_song, fast, slow   one-cycle command pulses
//   FL_DQ                 flash read data
//   FL_ADDR, FL_CE_N, FL_OE_N, FL_WE_N, FL_RST_N  flash address and controls
//   musicData             current sample {hi byte, lo byte}
//   sample_valid          one-cycle pulse when musicData takes a new sample
//   SecondSong            current song index
//   speed                 0 = slow, 1 = normal, 2 = fast
//   overrun               one-cycle pulse when a sample_req hits a busy fetch
module playback_sequencer #(
   parameter logic [22:0] SONG0_START = 23'h000000,
   parameter logic [22:0] SONG0_END   = 23'h3FFFFF,
   parameter logic [22:0] SONG1_START = 23'h400000,
   parameter logic [22:0] SONG1_END   = 23'h7FFFFF,
   parameter int unsigned FL_WAIT     = 4
) (
   input  logic        CLOCK,
   input  logic        Reset,
   input  logic        play,
   input  logic        sample_req,
   input  logic        restart,
   input  logic        next_song,
   input  logic        prev_song,
   input  logic        fast,
   input  logic        slow,
   input  logic [7:0]  FL_DQ,
   output logic [22:0] FL_ADDR,
   output logic        FL_CE_N,
   output logic        FL_OE_N,
   output logic        FL_WE_N,
   output logic        FL_RST_N,
   output logic [15:0] musicData,
   output logic        sample_valid,
   output logic        SecondSong,
   output logic [1:0]  speed,
   output logic        overrun
);

   localparam int unsigned   CNT_W    = (FL_WAIT > 1) ? $clog2(FL_WAIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FL_WAIT - 1);

   typedef enum logic [2:0] {IDLE, WAIT, RD_LO, RD_HI, UPDATE} state_t;

   state_t           state;
   logic [22:0]      addr;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       lo_byte;
   logic [7:0]       hi_byte;
   logic             slow_skip;   // slow mode: next accepted request is skipped
   logic             pend_restart, pend_next, pend_prev, pend_fast, pend_slow;

   logic             want_song, want_restart, want_fast, want_slow;
   logic [22:0]      cmd_addr;
   logic             cmd_song;
   logic [1:0]       cmd_speed;
   logic             cmd_skip;
   logic             fetch_en;
   logic [22:0]      cur_start, cur_end, adv_addr;
   logic [23:0]      adv_sum;

   assign FL_WE_N = 1'b1;

   // Command state as it stands after applying everything pending plus this
   // cycle's pulses; a same-cycle sample_req fetches with these values.
   always_comb begin
      want_song    = pend_next | next_song | pend_prev | prev_song;
      want_restart = pend_restart | restart;
      want_fast    = pend_fast | fast;
      want_slow    = pend_slow | slow;
      cmd_addr     = addr;
      cmd_song     = SecondSong;
      cmd_speed    = speed;
      cmd_skip     = slow_skip;
      if (want_song) begin
         cmd_song = ~SecondSong;
         cmd_addr = SecondSong ? SONG0_START : SONG1_START;
      end else if (want_restart) begin
         cmd_addr = SecondSong ? SONG1_START : SONG0_START;
      end
      if (want_fast && !want_slow && speed != 2'd2) begin
         cmd_speed = speed + 2'd1;
         cmd_skip  = 1'b0;
      end else if (want_slow && !want_fast && speed != 2'd0) begin
         cmd_speed = speed - 2'd1;
         cmd_skip  = 1'b0;
      end
      fetch_en = (cmd_speed != 2'd0) || !cmd_skip;
   end

   // Address advance with whole-sample wrap back to the song start.
   always_comb begin
      cur_start = SecondSong ? SONG1_START : SONG0_START;
      cur_end   = SecondSong ? SONG1_END : SONG0_END;
      adv_sum   = {1'b0, addr} + ((speed == 2'd2) ? 24'd4 : 24'd2);
      if (adv_sum + 24'd1 > {1'b0, cur_end}) adv_addr = cur_start;
      else                                   adv_addr = adv_sum[22:0];
   end

   always_ff @(posedge CLOCK) begin
      if (Reset) begin
         state        <= IDLE;
         addr         <= SONG0_START;
         FL_ADDR      <= SONG0_START;
         SecondSong   <= 1'b0;
         speed        <= 2'd1;
         musicData    <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
         FL_CE_N      <= 1'b1;
         FL_OE_N      <= 1'b1;
         FL_RST_N     <= 1'b0;
         cnt          <= '0;
         lo_byte      <= '0;
         hi_byte      <= '0;
         slow_skip    <= 1'b0;
         pend_restart <= 1'b0;
         pend_next    <= 1'b0;
         pend_prev    <= 1'b0;
         pend_fast    <= 1'b0;
         pend_slow    <= 1'b0;
      end else begin
         FL_RST_N     <= 1'b1;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
         if (!play) musicData <= '0;
         pend_restart <= pend_restart | restart;
         pend_next    <= pend_next | next_song;
         pend_prev    <= pend_prev | prev_song;
         pend_fast    <= pend_fast | fast;
         pend_slow    <= pend_slow | slow;
         case (state)
            IDLE, WAIT: begin
               addr         <= cmd_addr;
               SecondSong   <= cmd_song;
               speed        <= cmd_speed;
               slow_skip    <= cmd_skip;
               pend_restart <= 1'b0;
               pend_next    <= 1'b0;
               pend_prev    <= 1'b0;
               pend_fast    <= 1'b0;
               pend_slow    <= 1'b0;
               if (state == IDLE) begin
                  state <= WAIT;
               end else if (sample_req && play) begin
                  if (cmd_speed == 2'd0) slow_skip <= ~cmd_skip;
                  if (fetch_en) begin
                     state   <= RD_LO;
                     FL_ADDR <= cmd_addr;
                     FL_CE_N <= 1'b0;
                     FL_OE_N <= 1'b0;
                     cnt     <= '0;
                  end
               end
            end
            RD_LO: begin
               overrun <= sample_req;
               if (cnt == CNT_LAST) begin
                  lo_byte <= FL_DQ;
                  FL_ADDR <= addr + 23'd1;
                  cnt     <= '0;
                  state   <= RD_HI;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RD_HI: begin
               overrun <= sample_req;
               if (cnt == CNT_LAST) begin
                  hi_byte <= FL_DQ;
                  FL_CE_N <= 1'b1;
                  FL_OE_N <= 1'b1;
                  cnt     <= '0;
                  state   <= UPDATE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            UPDATE: begin
               overrun      <= sample_req;
               musicData    <= play ? {hi_byte, lo_byte} : 16'h0000;
               sample_valid <= 1'b1;
               addr         <= adv_addr;
               state        <= WAIT;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_playback_sequencer.sv
// tb_playback_sequencer
//   Self-checking bench for playback_sequencer with a small song map
//   (song 0 = 0..15, song 1 = 0x100000..0x10000F), FL_WAIT = 2 and a flash
//   model that returns the low address byte. Inputs are driven and outputs
//   sampled on the falling clock edge.
module tb_playback_sequencer;

   localparam logic [22:0] S0S = 23'h000000;
   localparam logic [22:0] S0E = 23'h00000F;
   localparam logic [22:0] S1S = 23'h100000;
   localparam logic [22:0] S1E = 23'h10000F;
   localparam int          FLW = 2;

   localparam logic [4:0] C_RST  = 5'b00001;
   localparam logic [4:0] C_NEXT = 5'b00010;
   localparam logic [4:0] C_PREV = 5'b00100;
   localparam logic [4:0] C_FAST = 5'b01000;
   localparam logic [4:0] C_SLOW = 5'b10000;

   logic        CLOCK = 1'b0;
   logic        Reset = 1'b1;
   logic        play = 1'b1;
   logic        sample_req = 1'b0;
   logic        restart = 1'b0, next_song = 1'b0, prev_song = 1'b0;
   logic        fast = 1'b0, slow = 1'b0;
   logic [7:0]  FL_DQ;
   logic [22:0] FL_ADDR;
   logic        FL_CE_N, FL_OE_N, FL_WE_N, FL_RST_N;
   logic [15:0] musicData;
   logic        sample_valid, SecondSong, overrun;
   logic [1:0]  speed;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int          m_song;
   logic [22:0] m_addr;
   int          m_speed;
   int          m_slow_cnt;
   logic [15:0] m_music;
   logic [4:0]  m_pend;

   playback_sequencer #(
      .SONG0_START(S0S), .SONG0_END(S0E),
      .SONG1_START(S1S), .SONG1_END(S1E),
      .FL_WAIT(FLW)
   ) dut (
      .CLOCK(CLOCK), .Reset(Reset), .play(play), .sample_req(sample_req),
      .restart(restart), .next_song(next_song), .prev_song(prev_song),
      .fast(fast), .slow(slow), .FL_DQ(FL_DQ), .FL_ADDR(FL_ADDR),
      .FL_CE_N(FL_CE_N), .FL_OE_N(FL_OE_N), .FL_WE_N(FL_WE_N),
      .FL_RST_N(FL_RST_N), .musicData(musicData), .sample_valid(sample_valid),
      .SecondSong(SecondSong), .speed(speed), .overrun(overrun)
   );

   assign FL_DQ = FL_ADDR[7:0];
   always #5 CLOCK = ~CLOCK;

   function automatic logic [22:0] song_start(int s);
      return (s == 1) ? S1S : S0S;
   endfunction

   function automatic logic [22:0] song_end(int s);
      return (s == 1) ? S1E : S0E;
   endfunction

   function automatic logic [15:0] sample_of(logic [22:0] a);
      logic [22:0] a1;
      a1 = a + 23'd1;
      return {a1[7:0], a[7:0]};
   endfunction

   function void model_reset();
      m_song = 0; m_addr = S0S; m_speed = 1; m_slow_cnt = 0;
      m_music = 16'h0000; m_pend = 5'b0;
   endfunction

   function void model_apply();
      int ns;
      if (m_pend[1] || m_pend[2]) begin
         m_song = 1 - m_song;
         m_addr = song_start(m_song);
      end else if (m_pend[0]) begin
         m_addr = song_start(m_song);
      end
      ns = m_speed;
      if (m_pend[3] && !m_pend[4]) ns = (m_speed < 2) ? m_speed + 1 : 2;
      if (m_pend[4] && !m_pend[3]) ns = (m_speed > 0) ? m_speed - 1 : 0;
      if (ns != m_speed) begin
         m_speed = ns;
         m_slow_cnt = 0;
      end
      m_pend = 5'b0;
   endfunction

   // One request evaluated after pending commands; returns fetch and address.
   function void model_req(input logic pl, output bit f, output logic [22:0] a);
      logic [23:0] nxt;
      model_apply();
      f = 1'b0;
      a = m_addr;
      if (!pl) begin
         m_music = 16'h0000;
         return;
      end
      if (m_speed == 0) begin
         f = (m_slow_cnt % 2) == 0;
         m_slow_cnt++;
      end else begin
         f = 1'b1;
      end
      if (f) begin
         m_music = sample_of(a);
         nxt = {1'b0, a} + ((m_speed == 2) ? 24'd4 : 24'd2);
         if (nxt + 24'd1 > {1'b0, song_end(m_song)}) m_addr = song_start(m_song);
         else m_addr = nxt[22:0];
      end
   endfunction

   task automatic drive_cmd(input logic [4:0] c);
      restart = c[0]; next_song = c[1]; prev_song = c[2]; fast = c[3]; slow = c[4];
   endtask

   task automatic do_reset();
      @(negedge CLOCK);
      Reset = 1'b1; play = 1'b1; sample_req = 1'b0; drive_cmd(5'b0);
      repeat (2) @(negedge CLOCK);
      Reset = 1'b0;
      repeat (2) @(negedge CLOCK);
      model_reset();
   endtask

   task automatic pulse_cmd(input logic [4:0] c);
      drive_cmd(c);
      @(negedge CLOCK);
      drive_cmd(5'b0);
      @(negedge CLOCK);
      m_pend |= c;
      model_apply();
   endtask

   // Issues a request (plus optional same-cycle command, mid-fetch command and
   // a second request) and records what the DUT does over a fixed window.
   task automatic req_cycle(input logic [4:0] cmd_now, input logic [4:0] cmd_mid,
                            input int mid_at, input int req2_at,
                            output int vld_at, output int ovr_at, output int ce_n,
                            output logic [22:0] a_lo, output logic [22:0] a_hi,
                            output logic [15:0] data);
      vld_at = 0; ovr_at = 0; ce_n = 0; a_lo = '0; a_hi = '0; data = '0;
      sample_req = 1'b1;
      drive_cmd(cmd_now);
      for (int k = 1; k <= 10; k++) begin
         @(negedge CLOCK);
         sample_req = (k == req2_at);
         drive_cmd((k == mid_at) ? cmd_mid : 5'b0);
         if (sample_valid && vld_at == 0) begin
            vld_at = k;
            data = musicData;
         end
         if (overrun && ovr_at == 0) ovr_at = k;
         if (!FL_CE_N) begin
            if (ce_n == 0) a_lo = FL_ADDR;
            a_hi = FL_ADDR;
            ce_n++;
         end
      end
      sample_req = 1'b0;
      drive_cmd(5'b0);
   endtask

   task automatic test_reset();
      @(negedge CLOCK);
      Reset = 1'b1;
      repeat (2) @(negedge CLOCK);
      vectors++;
      if ({FL_CE_N, FL_OE_N, FL_WE_N, FL_RST_N} !== 4'b1110) begin
         miscompares++;
         $display("FAIL reset_ctl: got %b exp 1110", {FL_CE_N, FL_OE_N, FL_WE_N, FL_RST_N});
      end
      vectors++;
      if ({FL_ADDR, SecondSong, speed, musicData, sample_valid, overrun} !== {23'h0, 1'b0, 2'd1, 16'h0, 2'b00}) begin
         miscompares++;
         $display("FAIL reset_vals: addr=%h song=%b speed=%0d data=%h vld=%b ovr=%b exp 0/0/1/0/0/0",
                  FL_ADDR, SecondSong, speed, musicData, sample_valid, overrun);
      end
      Reset = 1'b0;
      @(negedge CLOCK);
      vectors++;
      if (FL_RST_N !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_release: FL_RST_N got %b exp 1", FL_RST_N);
      end
      @(negedge CLOCK);
      model_reset();
   endtask

   task automatic test_normal_fetch();
      int v, o, n; logic [22:0] al, ah; logic [15:0] d; bit f; logic [22:0] ea;
      do_reset();
      model_req(1'b1, f, ea);
      req_cycle(5'b0, 5'b0, 0, 0, v, o, n, al, ah, d);
      vectors++;
      if (v !== 2 * FLW + 2 || n !== 2 * FLW) begin
         miscompares++;
         $display("FAIL fetch_timing: valid_at=%0d ce_cycles=%0d exp %0d/%0d", v, n, 2 * FLW + 2, 2 * FLW);
      end
      vectors++;
      if (al !== 23'd0 || ah !== 23'd1 || d !== 16'h0100) begin
         miscompares++;
         $display("FAIL fetch_data: lo=%h hi=%h data=%h exp 0/1/0100", al, ah, d);
      end
      model_req(1'b1, f, ea);
      req_cycle(5'b0, 5'b0, 0, 0, v, o, n, al, ah, d);
      vectors++;
      if (al !== 23'd2 || d !== 16'h0302) begin
         miscompares++;
         $display("FAIL fetch_advance: lo=%h data=%h exp 2/0302", al, d);
      end
   endtask

   task automatic test_wrap();
      int v, o, n; logic [22:0] al, ah; logic [15:0] d; bit f; logic [22:0] ea;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         model_req(1'b1, f, ea);
         req_cycle(5'b0, 5'b0, 0, 0, v, o, n, al, ah, d);
         vectors++;
         if (al !== ea || d !== sample_of(ea)) begin
            miscompares++;
            $display("FAIL wrap_seq[%0d]: addr=%h data=%h exp %h/%h", i, al, d, ea, sample_of(ea));
         end
         if (i == 7) begin
            vectors++;
            if (d !== 16'h0F0E) begin
               miscompares++;
               $display("FAIL wrap_last: data=%h exp 0f0e", d);
            end
         end
      end
      vectors++;
      if (al !== 23'd0 || d !== 16'h0100) begin
         miscompares++;
         $display("FAIL wrap_restart: addr=%h data=%h exp 0/0100", al, d);
      end
   endtask

   task automatic test_speed();
      int v, o, n; logic [22:0] al, ah; logic [15:0] d; bit f; logic [22:0] ea;
      logic [15:0] exp_fast [2];
      exp_fast[0] = 16'h0100;
      exp_fast[1] = 16'h0504;
      do_reset();
      pulse_cmd(C_FAST);
      vectors++;
      if (speed !== 2'd2) begin
         miscompares++;
         $display("FAIL speed_fast: got %0d exp 2", speed);
      end
      for (int i = 0; i < 2; i++) begin
         model_req(1'b1, f, ea);
         req_cycle(5'b0, 5'b0, 0, 0, v, o, n, al, ah, d);
         vectors++;
         if (d !== exp_fast[i]) begin
            miscompares++;
            $display("FAIL fast_sample[%0d]: got %h exp %h", i, d, exp_fast[i]);
         end
      end
      pulse_cmd(C_SLOW);
      pulse_cmd(C_SLOW);
      vectors++;
      if (speed !== 2'd0) begin
         miscompares++;
         $display("FAIL speed_slow: got %0d exp 0", speed);
      end
      for (int i = 0; i < 4; i++) begin
         model_req(1'b1, f, ea);
         req_cycle(5'b0, 5'b0, 0, 0, v, o, n, al, ah, d);
         vectors++;
         if ((n != 0) !== ((i % 2) == 0) || (v != 0) !== ((i % 2) == 0)) begin
            miscompares++;
            $display("FAIL slow_alternate[%0d]: ce_cycles=%0d valid_at=%0d exp fetch=%0d", i, n, v, (i % 2) == 0);
         end
         vectors++;
         if (musicData !== m_music) begin
            miscompares++;
            $display("FAIL slow_hold[%0d]: data=%h exp %h", i, musicData, m_music);
         end
      end
      pulse_cmd(C_SLOW);
      vectors++;
      if (speed !== 2'd0) begin
         miscompares++;
         $display("FAIL speed_floor: got %0d exp 0", speed);
      end
   endtask

   task automatic test_song_change();
      int v, o, n; logic [22:0] al, ah; logic [15:0] d; bit f; logic [22:0] ea;
      do_reset();
      model_req(1'b1, f, ea);
      req_cycle(5'b0, C_NEXT, FLW + 1, 0, v, o, n, al, ah, d);
      m_pend |= C_NEXT;
      model_apply();
      vectors++;
      if (al !== 23'd0 || d !== 16'h0100) begin
         miscompares++;
         $display("FAIL song_midfetch: addr=%h data=%h exp 0/0100", al, d);
      end
      vectors++;
      if (SecondSong !== 1'b1) begin
         miscompares++;
         $display("FAIL song_next: SecondSong=%b exp 1", SecondSong);
      end
      model_req(1'b1, f, ea);
      req_cycle(5'b0, 5'b0, 0, 0, v, o, n, al, ah, d);
      vectors++;
      if (al !== S1S || ah !== S1S + 23'd1) begin
         miscompares++;
         $display("FAIL song1_addr: lo=%h hi=%h exp %h", al, ah, S1S);
      end
      m_pend |= C_NEXT | C_PREV;
      model_req(1'b1, f, ea);
      req_cycle(C_NEXT | C_PREV, 5'b0, 0, 0, v, o, n, al, ah, d);
      vectors++;
      if (SecondSong !== 1'b0 || al !== S0S) begin
         miscompares++;
         $display("FAIL song_both: SecondSong=%b addr=%h exp 0/%h", SecondSong, al, S0S);
      end
   endtask

   task automatic test_pause_overrun();
      int v, o, n; logic [22:0] al, ah; logic [15:0] d; bit f; logic [22:0] ea;
      do_reset();
      model_req(1'b1, f, ea);
      req_cycle(5'b0, 5'b0, 0, 0, v, o, n, al, ah, d);
      play = 1'b0;
      for (int i = 0; i < 2; i++) begin
         model_req(1'b0, f, ea);
         req_cycle(5'b0, 5'b0, 0, 0, v, o, n, al, ah, d);
         vectors++;
         if (n !== 0 || v !== 0 || musicData !== 16'h0000) begin
            miscompares++;
            $display("FAIL pause[%0d]: ce_cycles=%0d valid_at=%0d data=%h exp 0/0/0000", i, n, v, musicData);
         end
      end
      play = 1'b1;
      model_req(1'b1, f, ea);
      req_cycle(5'b0, 5'b0, 0, 0, v, o, n, al, ah, d);
      vectors++;
      if (al !== 23'd2 || d !== 16'h0302) begin
         miscompares++;
         $display("FAIL resume: addr=%h data=%h exp 2/0302", al, d);
      end
      model_req(1'b1, f, ea);
      req_cycle(5'b0, 5'b0, 0, 3, v, o, n, al, ah, d);
      vectors++;
      if (o !== 4 || n !== 2 * FLW || d !== sample_of(ea)) begin
         miscompares++;
         $display("FAIL overrun: ovr_at=%0d ce_cycles=%0d data=%h exp 4/%0d/%h", o, n, d, 2 * FLW, sample_of(ea));
      end
   endtask

   task automatic test_reset_mid_read();
      int v, o, n; logic [22:0] al, ah; logic [15:0] d; bit f; logic [22:0] ea;
      do_reset();
      pulse_cmd(C_NEXT);
      pulse_cmd(C_FAST);
      sample_req = 1'b1;
      @(negedge CLOCK);
      sample_req = 1'b0;
      restart = 1'b1;
      @(negedge CLOCK);
      restart = 1'b0;
      Reset = 1'b1;
      @(negedge CLOCK);
      vectors++;
      if (FL_CE_N !== 1'b1 || FL_RST_N !== 1'b0 || FL_ADDR !== 23'd0 || speed !== 2'd1 || SecondSong !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_midread: ce_n=%b rst_n=%b addr=%h speed=%0d song=%b exp 1/0/0/1/0",
                  FL_CE_N, FL_RST_N, FL_ADDR, speed, SecondSong);
      end
      Reset = 1'b0;
      repeat (2) @(negedge CLOCK);
      model_reset();
      model_req(1'b1, f, ea);
      req_cycle(5'b0, 5'b0, 0, 0, v, o, n, al, ah, d);
      vectors++;
      if (al !== 23'd0 || speed !== 2'd1 || SecondSong !== 1'b0 || d !== 16'h0100) begin
         miscompares++;
         $display("FAIL reset_after: addr=%h speed=%0d song=%b data=%h exp 0/1/0/0100", al, speed, SecondSong, d);
      end
   endtask

   task automatic test_random();
      int v, o, n, mid_at, req2; logic [22:0] al, ah; logic [15:0] d; bit f; logic [22:0] ea;
      logic [4:0] cnow, cmid; logic pl;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         cnow   = ($urandom_range(0, 9) < 3) ? 5'($urandom) : 5'b0;
         cmid   = ($urandom_range(0, 9) < 3) ? 5'($urandom) : 5'b0;
         mid_at = $urandom_range(1, 5);
         pl     = ($urandom_range(0, 9) < 8);
         play   = pl;
         m_pend |= cnow;
         model_req(pl, f, ea);
         req2 = (f && $urandom_range(0, 3) == 0) ? 3 : 0;
         req_cycle(cnow, cmid, mid_at, req2, v, o, n, al, ah, d);
         m_pend |= cmid;
         model_apply();
         vectors++;
         if (n !== (f ? 2 * FLW : 0) || v !== (f ? 2 * FLW + 2 : 0) || o !== ((req2 != 0) ? 4 : 0)) begin
            miscompares++;
            $display("FAIL rnd_timing[%0d]: ce=%0d vld=%0d ovr=%0d exp fetch=%0d ovr=%0d", i, n, v, o, f, req2 != 0);
         end
         if (f) begin
            vectors++;
            if (al !== ea || ah !== ea + 23'd1 || d !== sample_of(ea)) begin
               miscompares++;
               $display("FAIL rnd_fetch[%0d]: lo=%h hi=%h data=%h exp %h/%h", i, al, ah, d, ea, sample_of(ea));
            end
         end
         vectors++;
         if (musicData !== m_music || speed !== 2'(m_speed) || SecondSong !== 1'(m_song)) begin
            miscompares++;
            $display("FAIL rnd_state[%0d]: data=%h speed=%0d song=%b exp %h/%0d/%0d",
                     i, musicData, speed, SecondSong, m_music, m_speed, m_song);
         end
      end
      play = 1'b1;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_normal_fetch();
      test_wrap();
      test_speed();
      test_song_change();
      test_pause_overrun();
      test_reset_mid_read();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
